// File: rtl/nand_page_sequencer.sv
// nand_page_sequencer
// Drives one NAND flash port for page-read and page-program transactions.
// The client sees a valid/ready request channel, a byte stream for program
// data, a strobe stream for read data and a one-cycle response pulse. The
// flash sees CLE/ALE/WEN/REN/IO. Every pin is a register loaded from the
// state of the previous cycle, so pins trail the state machine by one clock.
module nand_page_sequencer #(
  parameter int N_BYTES = 16,
  parameter int T_WB    = 2
) (
  input  logic        clk,
  input  logic        rst,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [17:0] req_addr,
  // program data stream
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  // read data stream
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  // completion
  output logic        resp_valid,
  output logic        resp_fail,
  output logic        busy,
  // flash pins
  inout  wire  [7:0]  F_IO,
  output logic        F_CLE,
  output logic        F_ALE,
  output logic        F_WEN,
  output logic        F_REN,
  input  logic        F_RB
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PRE    = 4'd1,
    S_CMD    = 4'd2,
    S_ADDR   = 4'd3,
    S_WB     = 4'd4,
    S_RBW    = 4'd5,
    S_RD     = 4'd6,
    S_WR     = 4'd7,
    S_CONF   = 4'd8,
    S_ST_CMD = 4'd9,
    S_ST_RD  = 4'd10,
    S_RESP   = 4'd11
  } state_t;

  localparam logic [9:0] LAST_BYTE = 10'(N_BYTES - 1);
  localparam logic [7:0] LAST_WB   = 8'(T_WB - 1);

  // Control state. ph_reg splits every pin pulse into its two cycles:
  // 0 = strobe low (WEN/REN = 0), 1 = strobe high (flash latches on the rise).
  state_t      state_reg, state_next;
  logic        ph_reg, ph_next;
  logic [9:0]  byte_cnt_reg, byte_cnt_next;
  logic [7:0]  sub_cnt_reg, sub_cnt_next;   // address byte index / tWB wait
  logic        op_reg, op_next;
  logic [17:0] addr_reg, addr_next;
  logic        fail_reg, fail_next;

  // Registered pin and client outputs and their next values.
  logic        cle_reg, cle_next;
  logic        ale_reg, ale_next;
  logic        wen_reg, wen_next;
  logic        ren_reg, ren_next;
  logic [7:0]  io_reg, io_next;
  logic        oe_reg, oe_next;
  logic        wr_ready_reg, wr_ready_next;
  logic        rd_valid_reg, rd_valid_next;
  logic [7:0]  rd_data_reg, rd_data_next;
  logic        resp_valid_reg, resp_valid_next;
  logic        resp_fail_reg, resp_fail_next;

  // A program byte is taken only while waiting in the first half of WR.
  logic        wr_fire;
  assign wr_fire = (state_reg == S_WR) && !ph_reg && wr_valid && wr_ready_reg;

  assign req_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign wr_ready   = wr_ready_reg;
  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_fail  = resp_fail_reg;
  assign F_CLE      = cle_reg;
  assign F_ALE      = ale_reg;
  assign F_WEN      = wen_reg;
  assign F_REN      = ren_reg;
  assign F_IO       = oe_reg ? io_reg : 8'bz;

  // State register: control state, counters and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ph_reg       <= 1'b0;
      byte_cnt_reg <= '0;
      sub_cnt_reg  <= '0;
      op_reg       <= 1'b0;
      addr_reg     <= '0;
      fail_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ph_reg       <= ph_next;
      byte_cnt_reg <= byte_cnt_next;
      sub_cnt_reg  <= sub_cnt_next;
      op_reg       <= op_next;
      addr_reg     <= addr_next;
      fail_reg     <= fail_next;
    end
  end

  // Next-state logic: sequences pulses, counts bytes and waits on R/B.
  always_comb begin
    state_next    = state_reg;
    ph_next       = ph_reg;
    byte_cnt_next = byte_cnt_reg;
    sub_cnt_next  = sub_cnt_reg;
    op_next       = op_reg;
    addr_next     = addr_reg;
    fail_next     = fail_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          op_next       = req_op;
          addr_next     = req_addr;
          byte_cnt_next = '0;
          sub_cnt_next  = '0;
          ph_next       = 1'b0;
          fail_next     = 1'b0;
          // second-half programs need the 0x01 pointer command first
          state_next    = (req_op && req_addr[8]) ? S_PRE : S_CMD;
        end
      end
      S_PRE: begin
        ph_next = ~ph_reg;
        if (ph_reg) state_next = S_CMD;
      end
      S_CMD: begin
        ph_next = ~ph_reg;
        if (ph_reg) begin
          state_next   = S_ADDR;
          sub_cnt_next = '0;
        end
      end
      S_ADDR: begin
        ph_next = ~ph_reg;
        if (ph_reg) begin
          if (sub_cnt_reg == 8'd2) begin
            sub_cnt_next = '0;
            state_next   = op_reg ? S_WR : S_WB;
          end else begin
            sub_cnt_next = sub_cnt_reg + 8'd1;
          end
        end
      end
      S_WB: begin
        // hold off R/B sampling until the flash has had time to go busy
        if (sub_cnt_reg == LAST_WB) begin
          sub_cnt_next = '0;
          state_next   = S_RBW;
        end else begin
          sub_cnt_next = sub_cnt_reg + 8'd1;
        end
      end
      S_RBW: begin
        if (F_RB) begin
          ph_next    = 1'b0;
          state_next = op_reg ? S_ST_CMD : S_RD;
        end
      end
      S_RD: begin
        ph_next = ~ph_reg;
        if (ph_reg) begin
          byte_cnt_next = byte_cnt_reg + 10'd1;
          if (byte_cnt_reg == LAST_BYTE) state_next = S_RESP;
        end
      end
      S_WR: begin
        if (!ph_reg) begin
          if (wr_fire) ph_next = 1'b1;
        end else begin
          ph_next       = 1'b0;
          byte_cnt_next = byte_cnt_reg + 10'd1;
          if (byte_cnt_reg == LAST_BYTE) state_next = S_CONF;
        end
      end
      S_CONF: begin
        ph_next = ~ph_reg;
        if (ph_reg) begin
          state_next   = S_WB;
          sub_cnt_next = '0;
        end
      end
      S_ST_CMD: begin
        ph_next = ~ph_reg;
        if (ph_reg) state_next = S_ST_RD;
      end
      S_ST_RD: begin
        ph_next = ~ph_reg;
        if (ph_reg) begin
          // edge ending the REN=0 cycle: status byte is valid on IO
          fail_next  = F_IO[0];
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: pin and stream values to be registered at the next edge.
  always_comb begin
    cle_next        = 1'b0;
    ale_next        = 1'b0;
    wen_next        = 1'b1;
    ren_next        = 1'b1;
    io_next         = io_reg;
    oe_next         = 1'b0;
    wr_ready_next   = (state_next == S_WR) && !ph_next;
    rd_valid_next   = 1'b0;
    rd_data_next    = rd_data_reg;
    resp_valid_next = 1'b0;
    resp_fail_next  = 1'b0;
    unique case (state_reg)
      S_PRE: begin
        cle_next = 1'b1;
        oe_next  = 1'b1;
        io_next  = 8'h01;
        wen_next = ph_reg;
      end
      S_CMD: begin
        cle_next = 1'b1;
        oe_next  = 1'b1;
        io_next  = op_reg ? 8'h80 : (addr_reg[8] ? 8'h01 : 8'h00);
        wen_next = ph_reg;
      end
      S_ADDR: begin
        ale_next = 1'b1;
        oe_next  = 1'b1;
        wen_next = ph_reg;
        case (sub_cnt_reg[1:0])
          2'd0:    io_next = addr_reg[7:0];
          2'd1:    io_next = addr_reg[16:9];
          2'd2:    io_next = {7'b0, addr_reg[17]};
          default: io_next = 8'h00;
        endcase
      end
      S_WR: begin
        // IO keeps the last byte while stalled; a new byte drops WEN at once
        oe_next = 1'b1;
        if (wr_fire) begin
          wen_next = 1'b0;
          io_next  = wr_data;
        end
      end
      S_CONF: begin
        cle_next = 1'b1;
        oe_next  = 1'b1;
        io_next  = 8'h10;
        wen_next = ph_reg;
      end
      S_ST_CMD: begin
        cle_next = 1'b1;
        oe_next  = 1'b1;
        io_next  = 8'h70;
        wen_next = ph_reg;
      end
      S_RD: begin
        ren_next = ph_reg;
        if (ph_reg) begin
          rd_valid_next = 1'b1;
          rd_data_next  = F_IO;
        end
      end
      S_ST_RD: begin
        ren_next = ph_reg;
      end
      S_RESP: begin
        resp_valid_next = 1'b1;
        resp_fail_next  = fail_reg;
      end
      default: begin
      end
    endcase
  end

  // Output registers: every pin and client strobe comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cle_reg        <= 1'b0;
      ale_reg        <= 1'b0;
      wen_reg        <= 1'b1;
      ren_reg        <= 1'b1;
      io_reg         <= 8'h00;
      oe_reg         <= 1'b0;
      wr_ready_reg   <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= 8'h00;
      resp_valid_reg <= 1'b0;
      resp_fail_reg  <= 1'b0;
    end else begin
      cle_reg        <= cle_next;
      ale_reg        <= ale_next;
      wen_reg        <= wen_next;
      ren_reg        <= ren_next;
      io_reg         <= io_next;
      oe_reg         <= oe_next;
      wr_ready_reg   <= wr_ready_next;
      rd_valid_reg   <= rd_valid_next;
      rd_data_reg    <= rd_data_next;
      resp_valid_reg <= resp_valid_next;
      resp_fail_reg  <= resp_fail_next;
    end
  end

endmodule

// File: tb/tb_nand_page_sequencer.sv
// Bench for nand_page_sequencer: a behavioural flash model on the pins,
// a table of transactions, and scoreboard queues of expected IO latches
// and read bytes filled at request time and drained as the DUT produces them.
module tb_nand_page_sequencer;
  localparam int N   = 16;
  localparam int TWB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [17:0] req_addr = '0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        resp_valid;
  logic        resp_fail;
  logic        busy;
  wire  [7:0]  f_io;
  logic        f_cle, f_ale, f_wen, f_ren;
  logic        rb = 1'b1;

  always #5 clk = ~clk;

  nand_page_sequencer #(.N_BYTES(N), .T_WB(TWB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .resp_valid(resp_valid), .resp_fail(resp_fail), .busy(busy),
    .F_IO(f_io), .F_CLE(f_cle), .F_ALE(f_ale), .F_WEN(f_wen), .F_REN(f_ren), .F_RB(rb)
  );

  // Flash model: drives IO while REN is low; page data depends on the
  // latched column/row bytes, status appears after a 0x70 command.
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] m_col = 8'h00;
  logic [7:0] m_row = 8'h00;
  logic [7:0] m_status = 8'h00;
  int         m_ale_n = 0;
  int         rd_idx = 0;
  logic [7:0] flash_dout;
  assign flash_dout = (last_cmd == 8'h70) ? m_status : ((m_col + 8'(rd_idx)) ^ m_row ^ 8'h5A);
  assign f_io = (f_ren == 1'b0) ? flash_dout : 8'bz;

  typedef struct {
    logic        op;
    logic [17:0] addr;
    logic [7:0]  status;
    int          stall_at;   // byte index to stall before, -1 = none
    int          rb_hold;    // cycles of R/B low after 0x10, 0 = none
    logic        exp_fail;
    int          exp_lat;    // cycles accept->resp_valid, 0 = not checked
  } vec_t;

  typedef struct packed {
    logic       cle;
    logic       ale;
    logic [7:0] io;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  vec_t       tbl[6];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    wr_t        obs, exp;
    logic [7:0] stall_byte;
    logic [7:0] exp_rd;
    logic       prev_wen, prev_ren, prev_fire, got_resp;
    int         cyc, widx, stall_left, rb_left, data_wr, busy_viol, stall_viol;
    exp_wr_q.delete();
    exp_rd_q.delete();
    if (v.op && v.addr[8]) exp_wr_q.push_back({1'b1, 1'b0, 8'h01});
    exp_wr_q.push_back({1'b1, 1'b0, v.op ? 8'h80 : (v.addr[8] ? 8'h01 : 8'h00)});
    exp_wr_q.push_back({1'b0, 1'b1, v.addr[7:0]});
    exp_wr_q.push_back({1'b0, 1'b1, v.addr[16:9]});
    exp_wr_q.push_back({1'b0, 1'b1, {7'b0, v.addr[17]}});
    if (v.op) begin
      for (int i = 0; i < N; i++) exp_wr_q.push_back({1'b0, 1'b0, 8'(i) + v.addr[7:0]});
      exp_wr_q.push_back({1'b1, 1'b0, 8'h10});
      exp_wr_q.push_back({1'b1, 1'b0, 8'h70});
    end else begin
      for (int i = 0; i < N; i++) exp_rd_q.push_back((v.addr[7:0] + 8'(i)) ^ v.addr[16:9] ^ 8'h5A);
    end
    stall_byte = 8'(v.stall_at - 1) + v.addr[7:0];
    m_status = v.status;
    widx = 0; stall_left = 10; rb_left = 0; data_wr = 0; busy_viol = 0; stall_viol = 0;
    prev_fire = 1'b0; got_resp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
    wr_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("accept_busy", {31'b0, busy}, 32'd1);
    prev_wen = f_wen; prev_ren = f_ren;
    cyc = 0;
    while (!got_resp && cyc < 3000) begin
      // R/B countdown: strobes must stay idle while the flash is busy
      if (rb_left > 0) begin
        if (f_wen !== 1'b1 || f_ren !== 1'b1) busy_viol++;
        rb_left--;
        if (rb_left == 0) rb = 1'b1;
      end
      // flash latches IO on the WEN rise
      if (prev_wen == 1'b0 && f_wen == 1'b1) begin
        obs = {f_cle, f_ale, f_io};
        if (!f_cle && !f_ale) data_wr++;
        if (f_cle) begin
          last_cmd = f_io;
          m_ale_n = 0;
          if (f_io == 8'h00 || f_io == 8'h01) rd_idx = 0;
          if (f_io == 8'h10 && v.rb_hold > 0) begin
            rb = 1'b0;
            rb_left = v.rb_hold;
          end
        end
        if (f_ale) begin
          if (m_ale_n == 0) m_col = f_io;
          if (m_ale_n == 1) m_row = f_io;
          m_ale_n++;
        end
        if (exp_wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got 0x%0h want none", obs);
        end else begin
          exp = exp_wr_q.pop_front();
          check("wr_latch", 32'(obs), 32'(exp));
        end
      end
      if (prev_ren == 1'b0 && f_ren == 1'b1) rd_idx++;
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got 0x%0h want none", rd_data);
        end else begin
          exp_rd = exp_rd_q.pop_front();
          check("rd_byte", 32'(rd_data), 32'(exp_rd));
        end
      end
      if (resp_valid) begin
        got_resp = 1'b1;
        check("resp_fail", {31'b0, resp_fail}, {31'b0, v.exp_fail});
        check("resp_ready", {31'b0, req_ready}, 32'd1);
        if (v.exp_lat > 0) check("resp_latency", 32'(cyc), 32'(v.exp_lat));
      end
      // program data feeder with optional stall window
      if (v.op) begin
        if (prev_fire) widx++;
        if (widx < N) begin
          if (widx == v.stall_at && stall_left > 0) begin
            wr_valid = 1'b0;
            stall_left--;
            if (stall_left < 9 && !(f_wen === 1'b1 && f_io === stall_byte)) stall_viol++;
          end else begin
            wr_valid = 1'b1;
            wr_data = 8'(widx) + v.addr[7:0];
          end
        end else begin
          wr_valid = 1'b0;
        end
        prev_fire = wr_valid && wr_ready;
      end
      prev_wen = f_wen; prev_ren = f_ren;
      if (!got_resp) begin
        @(negedge clk);
        cyc++;
      end
    end
    wr_valid = 1'b0;
    if (!got_resp) begin
      total++; bad++;
      $display("FAIL resp_timeout: got none want resp_valid within 3000 cycles");
    end
    @(negedge clk);
    check("resp_pulse_len", {31'b0, resp_valid}, 32'd0);
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    if (v.op) check("data_bytes", 32'(data_wr), 32'(N));
    if (v.rb_hold > 0) check("busy_hold_strobes", 32'(busy_viol), 32'd0);
    if (v.stall_at >= 0) check("stall_hold", 32'(stall_viol), 32'd0);
    $display("txn op=%0d addr=0x%05h cycles=%0d resp_fail=%0d", v.op, v.addr, cyc, resp_fail);
  endtask

  initial begin
    int late_resp;
    //          op    addr       status  stall rb  fail  lat
    tbl[0] = '{1'b0, 18'h00010, 8'h00,  -1,   0,  1'b0, 44};
    tbl[1] = '{1'b1, 18'h20100, 8'h00,  -1,   0,  1'b0, 52};
    tbl[2] = '{1'b1, 18'h00033, 8'h01,  -1,   0,  1'b1, 50};
    tbl[3] = '{1'b1, 18'h1FE55, 8'hC0,  -1,   50, 1'b0, 0};
    tbl[4] = '{1'b1, 18'h00200, 8'h00,  6,    0,  1'b0, 0};
    tbl[5] = '{1'b0, 18'h3F1A5, 8'h00,  -1,   0,  1'b0, 44};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cle", {31'b0, f_cle}, 32'd0);
    check("rst_ale", {31'b0, f_ale}, 32'd0);
    check("rst_wen", {31'b0, f_wen}, 32'd1);
    check("rst_ren", {31'b0, f_ren}, 32'd1);
    check("rst_io_hiz", {31'b0, f_io === 8'bzzzzzzzz}, 32'd1);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_fail", {31'b0, resp_fail}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    for (int t = 0; t < 6; t++) run_txn(tbl[t]);

    // reset during the address phase aborts with reset pin values
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_addr = 18'h00123;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_addr_ale", {31'b0, f_ale}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_wen", {31'b0, f_wen}, 32'd1);
    check("abort_ren", {31'b0, f_ren}, 32'd1);
    check("abort_cle", {31'b0, f_cle}, 32'd0);
    check("abort_ale", {31'b0, f_ale}, 32'd0);
    check("abort_io_hiz", {31'b0, f_io === 8'bzzzzzzzz}, 32'd1);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    late_resp = 0;
    repeat (60) begin
      @(negedge clk);
      if (resp_valid) late_resp++;
    end
    check("abort_no_resp", 32'(late_resp), 32'd0);
    $display("txn reset-abort during ADDR");
    run_txn(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
